// File: rtl/uart_rx_byte_pkg.sv
// Shared UART definitions: FSM state encodings and baud divider helper.
// Intended for reuse by a future transmit block.
package uart_rx_byte_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Rounded CLK_HZ / (BAUD * OVERSAMPLE)
    function automatic int calc_tick_div(int clk_hz, int baud, int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_byte_tick.sv
// Free-running mod-DIV counter emitting a 1-cycle tick on wrap.
module baud_tick_gen #(
    parameter int DIV = 27
) (
    input  logic iCLK,
    input  logic iRST,
    output logic oTICK
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap;

    always_comb begin
        wrap  = (cnt_q == W'(DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign oTICK = wrap;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-byte holding register and valid/ready
// handshake; flags framing errors and overruns.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iRXD,
    output logic [7:0] oDATA,
    output logic       oVALID,
    input  logic       iREADY,
    output logic       oFRAME_ERR,
    output logic       oOVERRUN,
    output logic       oBUSY
);

    localparam int TICK_DIV = calc_tick_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    logic        tick;
    logic [1:0]  sync_q;
    logic        rx_s;
    uart_state_e state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        brk_q, brk_d;
    logic        complete;

    baud_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .oTICK (tick)
    );

    assign rx_s = sync_q[1];

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bidx_d   = bidx_q;
        shift_d  = shift_q;
        brk_d    = brk_q;
        ferr_d   = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // After a break, wait for the line to go high again
                if (brk_q) begin
                    if (rx_s) brk_d = 1'b0;
                end else if (!rx_s) begin
                    state_d = ST_START;
                    tcnt_d  = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt_q == MID) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            tcnt_d  = '0;
                            bidx_d  = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tcnt_q == LAST) begin
                        tcnt_d  = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bidx_d  = bidx_q + 3'd1;
                        if (bidx_q == 3'd7) state_d = ST_STOP;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tcnt_q == LAST) begin
                        state_d = ST_IDLE;
                        if (rx_s) begin
                            complete = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                            brk_d  = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (valid_q && iREADY) valid_d = 1'b0;
        if (complete) begin
            if (!valid_q || iREADY) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], iRXD};
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
        end
    end

    assign oDATA      = data_q;
    assign oVALID     = valid_q;
    assign oFRAME_ERR = ferr_q;
    assign oOVERRUN   = ovr_q;
    assign oBUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at default parameters (432 cycles/bit).
`timescale 1ns/1ps
module tb_uart_rx_byte;

    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, ovr, busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_start = 0;
    int rise_cyc = 0;
    int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0;
    int busy_cnt = 0, hold_viol = 0;
    logic vprev = 1'b0;
    logic hold_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic [7:0] got[$];

    uart_rx_byte dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iRXD       (rxd),
        .oDATA      (data),
        .oVALID     (valid),
        .iREADY     (ready),
        .oFRAME_ERR (ferr),
        .oOVERRUN   (ovr),
        .oBUSY      (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ferr) ferr_cnt++;
        if (ovr) ovr_cnt++;
        if (ferr && ovr) both_cnt++;
        if (busy) busy_cnt++;
        if (valid && ready) got.push_back(data);
        if (valid && !vprev) rise_cyc = cyc;
        if (hold_prev && data !== data_prev) hold_viol++;
        vprev = valid;
        hold_prev = valid && !ready;
        data_prev = data;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: time limit reached, end of test not reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input int per,
                              input logic stopb);
        rxd = 1'b0;
        t_start = cyc;
        step(per);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            step(per);
        end
        rxd = stopb;
        step(per);
    endtask

    task automatic test_reset;
        #5;
        n_checks++;
        if ({data, valid, ferr, ovr, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async: outs=%h required 000",
                     {data, valid, ferr, ovr, busy});
        end
        step(3);
        rst = 1'b0;
        step(2);
        n_checks++;
        if ({data, valid, ferr, ovr, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_release: outs=%h required 000",
                     {data, valid, ferr, ovr, busy});
        end
    endtask

    task automatic test_basic;
        int lat;
        got.delete();
        ready = 1'b0;
        send_frame(8'hA5, BIT, 1'b1);
        rxd = 1'b1;
        lat = rise_cyc - t_start;
        n_checks++;
        if (valid !== 1'b1 || data !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_data: valid=%b data=%h required 1 a5",
                     valid, data);
        end
        n_checks++;
        if (lat < 4070 || lat > 4125) begin
            n_fail++;
            $display("FAIL basic_latency: %0d cycles required ~4104", lat);
        end
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || got.size() != 1) begin
            n_fail++;
            $display("FAIL basic_pop: valid=%b pops=%0d required 0 1",
                     valid, got.size());
        end
        step(BIT);
    endtask

    task automatic test_frame_err;
        int f0 = ferr_cnt;
        got.delete();
        ready = 1'b1;
        send_frame(8'h3C, BIT, 1'b0);
        step(20 * BIT);
        n_checks++;
        if (ferr_cnt - f0 != 1 || valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err: pulses=%0d valid=%b busy=%b required 1 0 0",
                     ferr_cnt - f0, valid, busy);
        end
        rxd = 1'b1;
        step(BIT);
        send_frame(8'h01, BIT, 1'b1);
        rxd = 1'b1;
        step(BIT);
        n_checks++;
        if (got.size() != 1 || got[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL after_break: pops=%0d first=%h required 1 01",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_glitch;
        int b0 = busy_cnt;
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        got.delete();
        rxd = 1'b0;
        step(100);
        rxd = 1'b1;
        step(BIT);
        n_checks++;
        if (busy_cnt == b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_fsm: busy_cycles=%0d busy=%b required >0 0",
                     busy_cnt - b0, busy);
        end
        n_checks++;
        if (got.size() != 0 || valid !== 1'b0 || ferr_cnt != f0 || ovr_cnt != o0) begin
            n_fail++;
            $display("FAIL glitch_flags: pops=%0d valid=%b ferr=%0d ovr=%0d required 0",
                     got.size(), valid, ferr_cnt - f0, ovr_cnt - o0);
        end
    endtask

    task automatic test_back_to_back;
        int o0 = ovr_cnt;
        int h0 = hold_viol;
        got.delete();
        ready = 1'b0;
        send_frame(8'h11, BIT, 1'b1);
        send_frame(8'h22, BIT, 1'b1);
        rxd = 1'b1;
        step(BIT);
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h11 || hold_viol != h0) begin
            n_fail++;
            $display("FAIL overrun_hold: valid=%b data=%h viol=%0d required 1 11 0",
                     valid, data, hold_viol - h0);
        end
        n_checks++;
        if (ovr_cnt - o0 != 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: %0d pulses required 1", ovr_cnt - o0);
        end
        ready = 1'b1;
        step(2);
        got.delete();
        o0 = ovr_cnt;
        send_frame(8'h11, BIT, 1'b1);
        send_frame(8'h22, BIT, 1'b1);
        rxd = 1'b1;
        step(BIT);
        n_checks++;
        if (got.size() != 2 || got[0] !== 8'h11 || got[1] !== 8'h22
            || ovr_cnt != o0) begin
            n_fail++;
            $display("FAIL b2b_ready: pops=%0d ovr=%0d required 2 (11,22) 0",
                     got.size(), ovr_cnt - o0);
        end
    endtask

    task automatic test_reset_mid;
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        got.delete();
        ready = 1'b1;
        fork
            send_frame(8'hFF, BIT, 1'b1);
            begin
                step(3 * BIT);
                rst = 1'b1;
                #1;
                n_checks++;
                if (busy !== 1'b0 || valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_abort: busy=%b valid=%b required 0 0",
                             busy, valid);
                end
                step(5);
                rst = 1'b0;
            end
        join
        rxd = 1'b1;
        step(BIT);
        send_frame(8'h5A, BIT, 1'b1);
        rxd = 1'b1;
        step(BIT);
        n_checks++;
        if (got.size() != 1 || got[0] !== 8'h5A || ferr_cnt != f0
            || ovr_cnt != o0) begin
            n_fail++;
            $display("FAIL reset_mid: pops=%0d ferr=%0d ovr=%0d required 1 (5a) 0 0",
                     got.size(), ferr_cnt - f0, ovr_cnt - o0);
        end
    endtask

    task automatic test_baud_tol;
        logic [7:0] exp_b[6];
        int per[6];
        exp_b = '{8'h00, 8'hFF, 8'h55, 8'h00, 8'hFF, 8'h55};
        per = '{445, 445, 445, 419, 419, 419};
        got.delete();
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_frame(exp_b[i], per[i], 1'b1);
            rxd = 1'b1;
            step(per[i]);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got.size() <= i || got[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL baud_tol[%0d]: got=%h required %h (period %0d)",
                         i, (got.size() > i) ? got[i] : 8'hxx, exp_b[i], per[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_baud_tol();
        n_checks++;
        if (both_cnt != 0) begin
            n_fail++;
            $display("FAIL flags_exclusive: %0d cycles both set required 0",
                     both_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
